// File: rtl/midi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : midi_pkg
// Purpose  : Shared types and constants for the MIDI note receiver.
// Revision : 1.0 - initial release
// ============================================================================
package midi_pkg;

  // Status-byte upper nibbles the parser cares about
  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_PROG     = 4'hC;
  localparam logic [3:0] ST_CHPRESS  = 4'hD;

  // Byte class boundaries
  localparam logic [7:0] SYS_FIRST = 8'hF0;
  localparam logic [7:0] RT_FIRST  = 8'hF8;

  // Counter widths
  localparam int CNT_W     = 11;
  localparam int BIT_IDX_W = 3;
  localparam int DCNT_W    = 2;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    RS_NONE     = 2'd0,
    RS_NOTE_OFF = 2'd1,
    RS_NOTE_ON  = 2'd2,
    RS_SKIP     = 2'd3
  } run_status_t;

  // Program change and channel pressure carry a single data byte
  function automatic logic is_one_data(input logic [3:0] hi);
    return (hi == ST_PROG) || (hi == ST_CHPRESS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/midi_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : midi_uart_rx
// Purpose  : Two-flop input synchroniser plus 8N1 receiver sampling at
//            mid-bit. Emits a one-cycle byte_valid or frame_err per frame.
// Revision : 1.0 - initial release
// ============================================================================
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 31250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       midi_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  logic                 rx_meta_q, rx_s_q;
  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           byte_data_q, byte_data_d;
  logic                 byte_valid_q, byte_valid_d;
  logic                 frame_err_q, frame_err_d;

  // Bring the asynchronous line into the clock domain (idle high)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= midi_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receiver state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Next-state: confirm start at half a bit, then sample each bit one DIV later
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_s_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // A line that is high again at mid-start was only a glitch
          state_d   = rx_s_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            byte_valid_d = 1'b1;
            byte_data_d  = shift_q;
            state_d      = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = RX_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_WAIT_IDLE: begin
        if (rx_s_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: rtl/midi_note_receiver.sv
`default_nettype none
// ============================================================================
// Module   : midi_note_receiver
// Purpose  : MIDI serial receiver and Note On/Off parser driving a single
//            monophonic note (number, velocity, gate) with last-note priority.
// Revision : 1.0 - initial release
// ============================================================================
module midi_note_receiver
  import midi_pkg::*;
#(
  parameter int         CLK_HZ     = 50_000_000,
  parameter int         BAUD       = 31250,
  parameter logic [6:0] RESET_NOTE = 7'd69
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       midi_rx,
  input  logic [3:0] channel,
  input  logic       omni,
  output logic [6:0] MIDI_freq,
  output logic [6:0] velocity,
  output logic       gate,
  output logic       note_strobe,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  logic              rx_valid;
  logic [7:0]        rx_data;

  run_status_t       run_q, run_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              one_q, one_d;
  logic [6:0]        key_q, key_d;
  logic [6:0]        freq_q, freq_d;
  logic [6:0]        vel_q, vel_d;
  logic              gate_q, gate_d;
  logic              strobe_q, strobe_d;

  logic              ch_ok;
  logic [3:0]        hi;

  midi_uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_uart (
    .clk        (clk),
    .reset      (reset),
    .midi_rx    (midi_rx),
    .byte_valid (rx_valid),
    .byte_data  (rx_data),
    .frame_err  (frame_err)
  );

  assign hi    = rx_data[7:4];
  assign ch_ok = omni || (rx_data[3:0] == channel);

  // Parser and note-state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q    <= RS_NONE;
      dcnt_q   <= '0;
      one_q    <= 1'b0;
      key_q    <= '0;
      freq_q   <= RESET_NOTE;
      vel_q    <= '0;
      gate_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      run_q    <= run_d;
      dcnt_q   <= dcnt_d;
      one_q    <= one_d;
      key_q    <= key_d;
      freq_q   <= freq_d;
      vel_q    <= vel_d;
      gate_q   <= gate_d;
      strobe_q <= strobe_d;
    end
  end

  // Classify each received byte and apply a completed note message
  always_comb begin
    run_d    = run_q;
    dcnt_d   = dcnt_q;
    one_d    = one_q;
    key_d    = key_q;
    freq_d   = freq_q;
    vel_d    = vel_q;
    gate_d   = gate_q;
    strobe_d = 1'b0;
    if (rx_valid) begin
      if (rx_data >= RT_FIRST) begin
        // Real-time bytes may interleave anywhere; leave parser state alone
      end else if (rx_data >= SYS_FIRST) begin
        run_d  = RS_NONE;
        dcnt_d = '0;
      end else if (rx_data[7]) begin
        dcnt_d = '0;
        one_d  = is_one_data(hi);
        if (hi == ST_NOTE_OFF && ch_ok) begin
          run_d = RS_NOTE_OFF;
        end else if (hi == ST_NOTE_ON && ch_ok) begin
          run_d = RS_NOTE_ON;
        end else begin
          run_d = RS_SKIP;
        end
      end else if (run_q != RS_NONE) begin
        if (dcnt_q == '0 && !one_q) begin
          key_d  = rx_data[6:0];
          dcnt_d = DCNT_W'(1);
        end else begin
          // Message complete; running status stays for the next pair
          dcnt_d = '0;
          if (run_q == RS_NOTE_ON && rx_data[6:0] != 7'd0) begin
            freq_d   = key_q;
            vel_d    = rx_data[6:0];
            gate_d   = 1'b1;
            strobe_d = 1'b1;
          end else if ((run_q == RS_NOTE_ON || run_q == RS_NOTE_OFF) && key_q == freq_q) begin
            gate_d = 1'b0;
          end
        end
      end
    end
  end

  assign MIDI_freq   = freq_q;
  assign velocity    = vel_q;
  assign gate        = gate_q;
  assign note_strobe = strobe_q;
  assign byte_valid  = rx_valid;
  assign byte_data   = rx_data;

endmodule
`default_nettype wire
